// File: rtl/coef_ramp_interp.sv
`default_nettype none
// ============================================================================
// Module   : coef_ramp_interp
// Brief    : Captures NTAPS-tap complex frames and ramps the parallel
//            coefficient vector linearly from the previous frame to the new one.
// Revision : 1.0 - parametrised ramp with pending buffer and integrity flags
// ============================================================================
module coef_ramp_interp #(
  parameter int NTAPS      = 32,
  parameter int DW         = 16,
  parameter int LOG2_STEPS = 5
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       dv_in,
  input  logic [$clog2(NTAPS)-1:0]   index_in,
  input  logic signed [DW-1:0]       din_real,
  input  logic signed [DW-1:0]       din_imag,
  input  logic                       step_en,
  output logic [NTAPS*DW-1:0]        dout_real,
  output logic [NTAPS*DW-1:0]        dout_imag,
  output logic                       dv_out,
  output logic                       ramping,
  output logic                       frame_err,
  output logic                       overrun
);

  localparam int                    c_IW       = $clog2(NTAPS);
  localparam int                    c_AW       = DW + LOG2_STEPS + 1;
  localparam logic [c_IW-1:0]       c_LAST_IDX = c_IW'(NTAPS - 1);
  localparam logic [LOG2_STEPS-1:0] c_LAST_K   = '1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_RAMP  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [c_IW-1:0]       r_expected;
  logic [LOG2_STEPS-1:0] r_k;
  logic                  r_pend_valid;
  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;

  logic w_hit, w_commit, w_step, w_ramp_step, w_ramp_end;
  logic w_first, w_start, w_to_pend, w_reload;

  logic signed [DW-1:0] w_din [2];

  assign w_din[0] = din_real;
  assign w_din[1] = din_imag;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  always_comb begin
    w_hit        = dv_in && (index_in == r_expected);
    w_commit     = w_hit && (r_expected == c_LAST_IDX);
    w_step       = step_en && (r_state != S_EMPTY);
    w_ramp_step  = step_en && (r_state == S_RAMP);
    w_ramp_end   = w_ramp_step && (r_k == c_LAST_K);
    w_first      = w_commit && (r_state == S_EMPTY);
    w_start      = w_commit && (r_state == S_HOLD);
    w_to_pend    = w_commit && (r_state == S_RAMP);
    // A frame committed on the final step lands in pending and is consumed at once.
    w_reload     = w_ramp_end && (r_pend_valid || w_to_pend);
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_commit) w_state_next = S_HOLD;
      S_HOLD:  if (w_commit) w_state_next = S_RAMP;
      S_RAMP:  if (w_ramp_end && !w_reload) w_state_next = S_HOLD;
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= S_EMPTY;
      r_expected   <= '0;
      r_k          <= '0;
      r_pend_valid <= 1'b0;
      dv_out       <= 1'b0;
      ramping      <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      ramping   <= (w_state_next == S_RAMP);
      dv_out    <= w_step;
      frame_err <= dv_in && !w_hit;
      overrun   <= w_to_pend && r_pend_valid;

      if (w_start || w_reload) begin
        r_k <= '0;
      end else if (w_ramp_step) begin
        r_k <= r_k + 1'b1;
      end

      if (w_reload) begin
        r_pend_valid <= 1'b0;
      end else if (w_to_pend) begin
        r_pend_valid <= 1'b1;
      end

      if (dv_in) begin
        if (w_hit) begin
          r_expected <= r_expected + 1'b1;
        end else begin
          r_expected <= (index_in == '0) ? c_IW'(1) : '0;
        end
      end
    end
  end

  for (genvar gc = 0; gc < 2; gc++) begin : g_cmp
    for (genvar gt = 0; gt < NTAPS; gt++) begin : g_tap
      logic signed [DW-1:0]   r_prev, r_cur, r_pend, r_dout;
      logic signed [DW-1:0]   w_frame, w_pend_src;
      logic signed [DW:0]     w_delta;
      logic signed [c_AW-1:0] r_acc, w_acc_next;

      // The last tap is never buffered: it completes the frame as it arrives.
      if (gt == NTAPS - 1) begin : g_last
        assign w_frame = w_din[gc];
      end else begin : g_mid
        localparam logic [c_IW-1:0] c_TAP_IDX = c_IW'(gt);
        logic signed [DW-1:0] r_wbuf;

        always_ff @(posedge clk or negedge w_rst_n) begin
          if (!w_rst_n) begin
            r_wbuf <= '0;
          end else if (dv_in && (index_in == c_TAP_IDX)) begin
            r_wbuf <= w_din[gc];
          end
        end

        assign w_frame = r_wbuf;
      end

      assign w_delta    = {r_cur[DW-1], r_cur} - {r_prev[DW-1], r_prev};
      assign w_acc_next = r_acc + {{LOG2_STEPS{w_delta[DW]}}, w_delta};
      assign w_pend_src = w_to_pend ? w_frame : r_pend;

      always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
          r_prev <= '0;
          r_cur  <= '0;
          r_pend <= '0;
          r_acc  <= '0;
          r_dout <= '0;
        end else begin
          if (w_to_pend) begin
            r_pend <= w_frame;
          end
          if (w_first) begin
            r_prev <= w_frame;
            r_cur  <= w_frame;
            r_acc  <= {w_frame[DW-1], w_frame, {LOG2_STEPS{1'b0}}};
            r_dout <= w_frame;
          end else if (w_start) begin
            r_prev <= r_cur;
            r_cur  <= w_frame;
            r_acc  <= {r_cur[DW-1], r_cur, {LOG2_STEPS{1'b0}}};
          end else if (w_ramp_step) begin
            // On the final step w_acc_next is exactly cur scaled, the next ramp's start.
            r_acc  <= w_acc_next;
            r_dout <= w_acc_next[LOG2_STEPS +: DW];
            if (w_reload) begin
              r_prev <= r_cur;
              r_cur  <= w_pend_src;
            end
          end
        end
      end

      if (gc == 0) begin : g_re
        assign dout_real[gt*DW +: DW] = r_dout;
      end else begin : g_im
        assign dout_imag[gt*DW +: DW] = r_dout;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coef_ramp_interp.sv
`default_nettype none
// ============================================================================
// Module   : tb_coef_ramp_interp
// Brief    : Scoreboard bench for coef_ramp_interp (NTAPS=4, DW=16, LOG2_STEPS=2)
// Revision : 1.0
// ============================================================================
module tb_coef_ramp_interp;

  localparam int NT = 4;
  localparam int L  = 2;
  localparam int S  = 4;

  logic               clk      = 1'b0;
  logic               aresetn  = 1'b0;
  logic               dv_in    = 1'b0;
  logic               step_en  = 1'b0;
  logic [1:0]         index_in = '0;
  logic signed [15:0] din_real = '0;
  logic signed [15:0] din_imag = '0;
  logic [63:0]        dout_real, dout_imag;
  logic               dv_out, ramping, frame_err, overrun;

  coef_ramp_interp #(.NTAPS(4), .DW(16), .LOG2_STEPS(2)) dut (
    .clk(clk), .aresetn(aresetn), .dv_in(dv_in), .index_in(index_in),
    .din_real(din_real), .din_imag(din_imag), .step_en(step_en),
    .dout_real(dout_real), .dout_imag(dout_imag), .dv_out(dv_out),
    .ramping(ramping), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic [63:0] re;
    logic [63:0] im;
    bit          ramp;
  } exp_t;

  exp_t dq[$];
  int   ferr_q[$];
  int   ovr_q[$];
  exp_t mon_e;

  // Reference model: state 0=EMPTY 1=HOLD 2=RAMP; ramp output in closed form.
  int m_st, m_exp, m_k;
  bit m_pv;
  int m_wbuf[2][4], m_prev[2][4], m_cur[2][4], m_pend[2][4], m_dout[2][4];
  int fr_re[4], fr_im[4];

  task automatic m_reset();
    m_st = 0; m_exp = 0; m_k = 0; m_pv = 0;
    for (int c = 0; c < 2; c++)
      for (int t = 0; t < NT; t++) begin
        m_wbuf[c][t] = 0; m_prev[c][t] = 0; m_cur[c][t] = 0;
        m_pend[c][t] = 0; m_dout[c][t] = 0;
      end
  endtask

  function automatic logic [63:0] pack(int c);
    logic [63:0] v;
    int x;
    v = '0;
    for (int t = 0; t < NT; t++) begin
      x = m_dout[c][t];
      v[t*16 +: 16] = x[15:0];
    end
    return v;
  endfunction

  task automatic model_eval();
    int  st0;
    bit  step;
    bit  commit;
    int  din[2];
    int  idx;
    st0    = m_st;
    commit = 0;
    din[0] = din_real;
    din[1] = din_imag;
    step   = step_en && (st0 != 0);
    if (step && st0 == 2) begin
      m_k++;
      for (int c = 0; c < 2; c++)
        for (int t = 0; t < NT; t++)
          m_dout[c][t] = (m_prev[c][t] * S + (m_cur[c][t] - m_prev[c][t]) * m_k) >>> L;
    end
    if (dv_in) begin
      idx = index_in;
      if (idx == m_exp) begin
        for (int c = 0; c < 2; c++) m_wbuf[c][idx] = din[c];
        if (idx == NT - 1) begin commit = 1; m_exp = 0; end
        else m_exp++;
      end else begin
        ferr_q.push_back(cyc + 1);
        if (idx == 0) begin
          for (int c = 0; c < 2; c++) m_wbuf[c][0] = din[c];
          m_exp = 1;
        end else m_exp = 0;
      end
    end
    if (commit) begin
      if (st0 == 0) begin
        m_prev = m_wbuf; m_cur = m_wbuf; m_dout = m_wbuf; m_st = 1;
      end else if (st0 == 1) begin
        m_prev = m_cur; m_cur = m_wbuf; m_k = 0; m_st = 2;
      end else begin
        if (m_pv) ovr_q.push_back(cyc + 1);
        m_pend = m_wbuf; m_pv = 1;
      end
    end
    if (step && st0 == 2 && m_k == S) begin
      if (m_pv) begin
        m_prev = m_cur; m_cur = m_pend; m_pv = 0; m_k = 0;
      end else m_st = 1;
    end
    if (step) dq.push_back('{cyc + 1, pack(0), pack(1), (m_st == 2)});
  endtask

  always @(negedge clk) begin
    if (dv_out) begin
      checks++;
      if (dq.size() == 0 || dq[0].cyc != cyc) begin
        failures++;
        $display("FAIL dv_out_timing cyc=%0d actual dv_out=1 required no strobe", cyc);
      end else begin
        mon_e = dq.pop_front();
        if (dout_real !== mon_e.re || dout_imag !== mon_e.im || ramping !== mon_e.ramp) begin
          failures++;
          $display("FAIL dout cyc=%0d actual re=%h im=%h ramping=%0b required re=%h im=%h ramping=%0b",
                   cyc, dout_real, dout_imag, ramping, mon_e.re, mon_e.im, mon_e.ramp);
        end
      end
    end
    while (dq.size() > 0 && dq[0].cyc <= cyc) begin
      checks++; failures++;
      $display("FAIL dv_out_missing cyc=%0d actual dv_out=0 required 1", dq[0].cyc);
      void'(dq.pop_front());
    end
    if (frame_err) begin
      checks++;
      if (ferr_q.size() == 0 || ferr_q[0] != cyc) begin
        failures++;
        $display("FAIL frame_err cyc=%0d actual 1 required 0", cyc);
      end else void'(ferr_q.pop_front());
    end
    while (ferr_q.size() > 0 && ferr_q[0] <= cyc) begin
      checks++; failures++;
      $display("FAIL frame_err_missing cyc=%0d actual 0 required 1", ferr_q[0]);
      void'(ferr_q.pop_front());
    end
    if (overrun) begin
      checks++;
      if (ovr_q.size() == 0 || ovr_q[0] != cyc) begin
        failures++;
        $display("FAIL overrun cyc=%0d actual 1 required 0", cyc);
      end else void'(ovr_q.pop_front());
    end
    while (ovr_q.size() > 0 && ovr_q[0] <= cyc) begin
      checks++; failures++;
      $display("FAIL overrun_missing cyc=%0d actual 0 required 1", ovr_q[0]);
      void'(ovr_q.pop_front());
    end
  end

  task automatic chk(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int tap_re(int t);
    logic signed [15:0] s;
    s = dout_real[t*16 +: 16];
    return int'(s);
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, int step_pct);
    repeat (n) begin
      dv_in   = 1'b0;
      step_en = ($urandom_range(0, 99) < step_pct);
      tick();
    end
    step_en = 1'b0;
  endtask

  task automatic send_frame(int step_pct, bit faults);
    for (int t = 0; t < NT; t++) begin
      dv_in    = 1'b1;
      index_in = (faults && $urandom_range(0, 11) == 0) ? 2'($urandom_range(0, 3)) : 2'(t);
      din_real = 16'(fr_re[t]);
      din_imag = 16'(fr_im[t]);
      step_en  = ($urandom_range(0, 99) < step_pct);
      tick();
    end
    dv_in   = 1'b0;
    step_en = 1'b0;
  endtask

  task automatic step();
    dv_in   = 1'b0;
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_dout_real"}, (dout_real == '0) ? 0 : 1, 0);
    chk({nm, "_dout_imag"}, (dout_imag == '0) ? 0 : 1, 0);
    chk({nm, "_dv_out"}, dv_out, 0);
    chk({nm, "_ramping"}, ramping, 0);
  endtask

  task automatic reset_pulses();
    repeat (3) begin
      step_en = 1'b1; @(posedge clk); #1;
      step_en = 1'b0; @(posedge clk); #1;
    end
    aresetn = 1'b1;
    idle(4, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp0[4];
    int exp2[4];
    int fl[4];
    int bad_idx[3];
    m_reset();

    // Reset state, step strobes ignored
    @(posedge clk); #1;
    reset_pulses();
    chk_zero("reset");

    // First frame goes straight to the output
    fr_re = '{100, 200, -300, 400};
    fr_im = '{-1, 2, -3, 4};
    send_frame(0, 0);
    for (int t = 0; t < NT; t++) chk($sformatf("first_tap%0d", t), tap_re(t), fr_re[t]);
    chk("first_ramping", ramping, 0);
    step(); step();

    // Ramp to second frame
    fr_re = '{500, 200, 0, 400};
    fr_im = '{10, 20, 30, 40};
    send_frame(0, 0);
    chk("ramp_start_ramping", ramping, 1);
    exp0 = '{200, 300, 400, 500};
    exp2 = '{-225, -150, -75, 0};
    for (int s = 0; s < S; s++) begin
      step();
      chk($sformatf("ramp_tap0_s%0d", s), tap_re(0), exp0[s]);
      chk($sformatf("ramp_tap2_s%0d", s), tap_re(2), exp2[s]);
      chk($sformatf("ramp_ramping_s%0d", s), ramping, (s < S - 1) ? 1 : 0);
    end

    // Floor rounding toward -inf
    fr_re = '{500, 0, 0, 400}; send_frame(0, 0); repeat (S) step();
    fr_re = '{500, 3, 0, 400}; send_frame(0, 0);
    fl = '{0, 1, 2, 3};
    for (int s = 0; s < S; s++) begin
      step(); chk($sformatf("floor_pos_s%0d", s), tap_re(1), fl[s]);
    end
    fr_re = '{500, 0, 0, 400}; send_frame(0, 0); repeat (S) step();
    fr_re = '{500, -3, 0, 400}; send_frame(0, 0);
    fl = '{-1, -2, -3, -3};
    for (int s = 0; s < S; s++) begin
      step(); chk($sformatf("floor_neg_s%0d", s), tap_re(1), fl[s]);
    end

    // Out-of-order index discards the frame
    bad_idx = '{0, 1, 3};
    for (int i = 0; i < 3; i++) begin
      dv_in = 1'b1; index_in = 2'(bad_idx[i]); din_real = 16'(77 * i); din_imag = '0;
      tick();
    end
    dv_in = 1'b0;
    idle(2, 0);
    chk("frame_err_no_commit_ramping", ramping, 0);
    step();
    fr_re = '{-1000, 1000, 7, -7}; send_frame(0, 0);
    chk("after_err_ramping", ramping, 1);
    repeat (S) step();

    // Overrun: A then B during a ramp, next ramp targets B
    fr_re = '{1, 2, 3, 4}; send_frame(0, 0);
    fr_re = '{11, 12, 13, 14}; send_frame(0, 0);
    fr_re = '{-800, 800, -1600, 1600}; fr_im = '{5, 6, 7, 8}; send_frame(0, 0);
    repeat (S) step();
    chk("overrun_reload_ramping", ramping, 1);
    repeat (S) step();
    chk("overrun_target_tap0", tap_re(0), -800);
    chk("overrun_target_tap3", tap_re(3), 1600);
    chk("overrun_end_ramping", ramping, 0);

    // Asynchronous reset mid-ramp
    fr_re = '{3000, -3000, 0, 9}; send_frame(0, 0);
    step(); step();
    #2;
    aresetn = 1'b0;
    dq.delete(); ferr_q.delete(); ovr_q.delete();
    m_reset();
    #1;
    chk_zero("async_reset");
    @(posedge clk); #1;
    reset_pulses();

    // Randomised traffic
    repeat (150) begin
      for (int t = 0; t < NT; t++) begin
        fr_re[t] = int'($urandom_range(0, 65535)) - 32768;
        fr_im[t] = int'($urandom_range(0, 65535)) - 32768;
      end
      send_frame(40, 1);
      idle($urandom_range(0, 10), 50);
      if ($urandom_range(0, 3) == 0) idle(20, 100);
    end
    idle(10, 0);
    chk("scoreboard_drained", dq.size() + ferr_q.size() + ovr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coef_ramp_interp.md
Name: coef_ramp_interp

Overview:
- Parametrised successor to the fixed 32-tap linear interpolator on the fader path.
- Captures one windowed IFFT output frame of NTAPS complex taps, indexed by index_in.
- Ramps all taps linearly from the previous frame to the new one over 2^LOG2_STEPS sample strobes.
- Presents the full coefficient vector in parallel to the complex convolver. Adds frame integrity checking, pending-frame buffering and an overrun flag.

Parameters:
- NTAPS, 32, number of complex taps per frame (power of two, >=2)
- DW, 16, signed width of each real/imag component
- LOG2_STEPS, 5, log2 of interpolation steps per frame transition (1..10)

Ports:
- clk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- dv_in  in  1  input tap valid
- index_in  in  $clog2(NTAPS)  tap index of current input
- din_real  in  DW  signed tap real
- din_imag  in  DW  signed tap imag
- step_en  in  1  output sample strobe; advances ramp one step
- dout_real  out  NTAPS*DW  packed signed taps, tap i at [i*DW +: DW]
- dout_imag  out  NTAPS*DW  same for imag
- dv_out  out  1  one-cycle strobe: dout valid for this sample
- ramping  out  1  high while state RAMP
- frame_err  out  1  one-cycle pulse on out-of-order index
- overrun  out  1  one-cycle pulse when pending frame overwritten

Behaviour:
- Reset (async assert, sync deassert internally):
  - all outputs 0; state EMPTY; capture expected index 0; pending empty.
  - Applies immediately, including mid-ramp or mid-capture.
- Capture:
  - Write buffer filled in order 0..NTAPS-1.
  - dv_in with index_in == expected: store the tap and increment expected.
  - dv_in with index_in != expected: discard the partial frame and pulse frame_err next cycle. If index_in == 0, start a new frame with that tap (expected = 1); otherwise expected = 0.
  - Storing tap NTAPS-1 completes the frame (commit).
- States: EMPTY, HOLD, RAMP.
  - EMPTY + commit: prev = cur = frame; go to HOLD; dout = frame the next cycle.
  - HOLD + commit: prev = cur (the current dout), cur = frame; k = 0; go to RAMP.
  - RAMP + commit: frame goes to the pending buffer. If pending was already full, overwrite it and pulse overrun.
  - RAMP + step_en: k increments.
  - When k reaches 2^LOG2_STEPS and pending is full: prev = cur, cur = pending, clear pending, k = 0, stay in RAMP. Otherwise go to HOLD.
  - Commit and ramp end in the same cycle: the frame goes to pending first and is consumed at the same boundary.
- Arithmetic, per tap and per component:
  - delta = cur - prev, DW+1 bits signed.
  - Accumulator acc is DW+LOG2_STEPS+1 bits signed, initialised to prev <<< LOG2_STEPS, then acc += delta on each step.
  - dout = acc >>> LOG2_STEPS (arithmetic shift, floor).
  - At k = 2^LOG2_STEPS, dout equals cur exactly. No multipliers, no saturation needed.
- Output timing:
  - step_en in HOLD or RAMP: dout updated and dv_out = 1 on the cycle after step_en.
  - step_en in EMPTY: ignored; dv_out stays 0.
  - dout is registered and changes only on step_en, or on the first commit out of EMPTY.
  - step_en and commit in the same cycle: the step applies to the old ramp; the new frame takes effect as above.
- dv_in is never back-pressured; the block accepts one tap every cycle.

Test Plan:
(NTAPS=4, DW=16, LOG2_STEPS=2 unless noted)
1. Reset: hold aresetn=0 -> dout all 0, dv_out=0, ramping=0; step_en pulses ignored.
2. First frame: real taps 100, 200, -300, 400 at index 0..3 -> dout_real equals these one cycle after index 3; state HOLD; step_en gives dv_out one cycle later, values unchanged.
3. Ramp: second frame real 500, 200, 0, 400 -> four step_en strobes give tap0 200/300/400/500 and tap2 -225/-150/-75/0; ramping drops after the 4th step.
4. Floor rounding: tap prev 0, target 3 -> steps give 0, 1, 2, 3. With prev 0, target -3 -> -1, -2, -3, -3.
5. Frame error: indices 0, 1, 3 -> frame_err pulse, nothing committed; a following full 0..3 frame commits normally.
6. Overrun and async reset:
   - Commit frames A and B during a ramp -> overrun pulse on B; the next ramp targets B.
   - Drop aresetn mid-ramp -> outputs 0 within the same cycle.
